// File: rtl/wash_pkg.sv
// Shared definitions for the wash payment front-end and the washing machine controller:
// FSM state encoding, coin codes, coin value lookup and default prices.
package wash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CREDIT = 3'd1,
    ST_START  = 3'd2,
    ST_WASH   = 3'd3,
    ST_REFUND = 3'd4
  } wash_state_e;

  localparam logic [1:0] COIN_1U  = 2'b00;
  localparam logic [1:0] COIN_2U  = 2'b01;
  localparam logic [1:0] COIN_4U  = 2'b10;
  localparam logic [1:0] COIN_BAD = 2'b11;

  localparam int PRICE_SINGLE_DEF = 4;
  localparam int PRICE_DOUBLE_DEF = 6;
  localparam int CREDIT_MAX_DEF   = 20;

  // Value in units of a coin code; the invalid code maps to zero.
  function automatic logic [2:0] coin_value(input logic [1:0] code);
    logic [2:0] val;
    case (code)
      COIN_1U: val = 3'd1;
      COIN_2U: val = 3'd2;
      COIN_4U: val = 3'd4;
      default: val = 3'd0;
    endcase
    return val;
  endfunction

  function automatic logic coin_code_ok(input logic [1:0] code);
    return (code != COIN_BAD);
  endfunction

endpackage

// File: rtl/wash_coin_decoder.sv
// Coin decoder: maps a coin code to its value, checks the credit ceiling and
// raises a registered one-cycle reject pulse for every coin that is not taken.
module wash_coin_decoder
  import wash_pkg::*;
#(
  parameter int CREDIT_W   = 8,
  parameter int CREDIT_MAX = CREDIT_MAX_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid_i,
  input  logic [1:0]          coin_code_i,
  input  logic                window_i,
  input  logic [CREDIT_W-1:0] credit_i,
  output logic                coin_accept_o,
  output logic [CREDIT_W-1:0] coin_value_o,
  output logic                coin_reject_o
);

  localparam logic [CREDIT_W:0] CREDIT_MAX_C = (CREDIT_W+1)'(CREDIT_MAX);

  logic [CREDIT_W:0] sum_s;
  logic              fits_s;
  logic              coin_reject_q;

  // Value lookup and ceiling check; the sum carries one extra bit so it cannot wrap.
  always_comb begin
    coin_value_o  = CREDIT_W'(coin_value(coin_code_i));
    sum_s         = {1'b0, credit_i} + {1'b0, coin_value_o};
    fits_s        = (sum_s <= CREDIT_MAX_C);
    coin_accept_o = coin_valid_i & window_i & coin_code_ok(coin_code_i) & fits_s;
  end

  // Reject pulse appears the cycle after the offending coin strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coin_reject_q <= 1'b0;
    end else begin
      coin_reject_q <= coin_valid_i & ~coin_accept_o;
    end
  end

  assign coin_reject_o = coin_reject_q;

endmodule

// File: rtl/wash_payment_frontend.sv
// Payment and start front-end for the washing machine controller: credit accumulation,
// start pulse with wash mode, wash_done edge tracking, pause gating and refund handshake.
module wash_payment_frontend
  import wash_pkg::*;
#(
  parameter int CREDIT_W     = 8,
  parameter int PRICE_SINGLE = PRICE_SINGLE_DEF,
  parameter int PRICE_DOUBLE = PRICE_DOUBLE_DEF,
  parameter int CREDIT_MAX   = CREDIT_MAX_DEF,
  parameter int IDLE_TIMEOUT = 1000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [1:0]          coin_code,
  output logic                coin_reject,
  input  logic                start_req,
  input  logic                double_sel,
  input  logic                cancel_req,
  input  logic                pause_req,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                coin_in,
  output logic                double_wash,
  output logic                timer_pause,
  input  logic                wash_done,
  output logic                refund_valid,
  output logic [CREDIT_W-1:0] refund_amount,
  input  logic                refund_ack
);

  localparam int TMO_W = $clog2(IDLE_TIMEOUT + 1);

  wash_state_e         state_q;
  logic [CREDIT_W-1:0] credit_q;
  logic [CREDIT_W-1:0] refund_amount_q;
  logic                busy_q;
  logic                coin_in_q;
  logic                double_wash_q;
  logic                timer_pause_q;
  logic                refund_valid_q;
  logic                wash_done_q;
  logic [TMO_W-1:0]    tmo_q;

  logic [TMO_W-1:0]    tmo_d;
  logic [CREDIT_W-1:0] credit_add_d;
  logic [CREDIT_W-1:0] price_s;
  logic                start_ok_s;
  logic                coin_window_s;
  logic                coin_accept_s;
  logic [CREDIT_W-1:0] coin_val_s;
  logic                activity_s;
  logic                timeout_s;
  logic                wd_rise_s;

  // Event decode; a coin loses to a cancel or to a start that will actually fire.
  always_comb begin
    price_s       = double_sel ? CREDIT_W'(PRICE_DOUBLE) : CREDIT_W'(PRICE_SINGLE);
    start_ok_s    = (state_q == ST_CREDIT) && start_req && (credit_q >= price_s);
    coin_window_s = (state_q == ST_IDLE) ||
                    ((state_q == ST_CREDIT) && !cancel_req && !start_ok_s);
    activity_s    = coin_valid | start_req | cancel_req;
    timeout_s     = (tmo_q == TMO_W'(IDLE_TIMEOUT - 1)) && !activity_s;
    wd_rise_s     = wash_done && !wash_done_q;
    credit_add_d  = credit_q + coin_val_s;
    if ((state_q != ST_CREDIT) || activity_s) begin
      tmo_d = {TMO_W{1'b0}};
    end else begin
      tmo_d = tmo_q + TMO_W'(1);
    end
  end

  wash_coin_decoder #(
    .CREDIT_W  (CREDIT_W),
    .CREDIT_MAX(CREDIT_MAX)
  ) u_coin_decoder (
    .clk          (clk),
    .rst          (rst),
    .coin_valid_i (coin_valid),
    .coin_code_i  (coin_code),
    .window_i     (coin_window_s),
    .credit_i     (credit_q),
    .coin_accept_o(coin_accept_s),
    .coin_value_o (coin_val_s),
    .coin_reject_o(coin_reject)
  );

  // Main FSM with all customer and controller facing outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      credit_q        <= {CREDIT_W{1'b0}};
      refund_amount_q <= {CREDIT_W{1'b0}};
      busy_q          <= 1'b0;
      coin_in_q       <= 1'b0;
      double_wash_q   <= 1'b0;
      timer_pause_q   <= 1'b0;
      refund_valid_q  <= 1'b0;
      wash_done_q     <= 1'b0;
      tmo_q           <= {TMO_W{1'b0}};
    end else begin
      coin_in_q     <= 1'b0;
      wash_done_q   <= wash_done;
      timer_pause_q <= pause_req & busy_q;
      tmo_q         <= tmo_d;
      case (state_q)
        ST_IDLE: begin
          if (coin_accept_s) begin
            credit_q <= credit_add_d;
            state_q  <= ST_CREDIT;
          end
        end
        ST_CREDIT: begin
          if (cancel_req) begin
            refund_valid_q  <= 1'b1;
            refund_amount_q <= credit_q;
            state_q         <= ST_REFUND;
          end else if (start_ok_s) begin
            credit_q      <= credit_q - price_s;
            double_wash_q <= double_sel;
            busy_q        <= 1'b1;
            coin_in_q     <= 1'b1;
            state_q       <= ST_START;
          end else if (coin_accept_s) begin
            credit_q <= credit_add_d;
          end else if (timeout_s) begin
            refund_valid_q  <= 1'b1;
            refund_amount_q <= credit_q;
            state_q         <= ST_REFUND;
          end
        end
        ST_START: begin
          state_q <= ST_WASH;
        end
        ST_WASH: begin
          // Only a fresh rising edge of wash_done ends the wash, never a level left high.
          if (wd_rise_s) begin
            busy_q        <= 1'b0;
            double_wash_q <= 1'b0;
            if (credit_q != {CREDIT_W{1'b0}}) begin
              refund_valid_q  <= 1'b1;
              refund_amount_q <= credit_q;
              state_q         <= ST_REFUND;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_REFUND: begin
          if (refund_ack) begin
            credit_q        <= {CREDIT_W{1'b0}};
            refund_valid_q  <= 1'b0;
            refund_amount_q <= {CREDIT_W{1'b0}};
            state_q         <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign credit        = credit_q;
  assign busy          = busy_q;
  assign coin_in       = coin_in_q;
  assign double_wash   = double_wash_q;
  assign timer_pause   = timer_pause_q;
  assign refund_valid  = refund_valid_q;
  assign refund_amount = refund_amount_q;

endmodule

// File: tb/tb_wash_payment_frontend.sv
// Self-checking bench for wash_payment_frontend: scenario tasks with inline checks and
// a refund scoreboard filled when refunds are provoked and drained when the DUT offers them.
module tb_wash_payment_frontend;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_code = 2'b00;
  logic       start_req = 1'b0;
  logic       double_sel = 1'b0;
  logic       cancel_req = 1'b0;
  logic       pause_req = 1'b0;
  logic       wash_done = 1'b0;
  logic       refund_ack = 1'b0;
  logic       coin_reject, busy, coin_in, double_wash, timer_pause, refund_valid;
  logic [7:0] credit, refund_amount;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_refund_q[$];

  wash_payment_frontend #(.IDLE_TIMEOUT(10)) dut (
    .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_code(coin_code),
    .coin_reject(coin_reject), .start_req(start_req), .double_sel(double_sel),
    .cancel_req(cancel_req), .pause_req(pause_req), .credit(credit), .busy(busy),
    .coin_in(coin_in), .double_wash(double_wash), .timer_pause(timer_pause),
    .wash_done(wash_done), .refund_valid(refund_valid), .refund_amount(refund_amount),
    .refund_ack(refund_ack)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic coin(input logic [1:0] code);
    coin_valid = 1'b1; coin_code = code;
    tick();
    coin_valid = 1'b0;
  endtask

  task automatic start(input logic dbl);
    start_req = 1'b1; double_sel = dbl;
    tick();
    start_req = 1'b0;
  endtask

  task automatic ack();
    refund_ack = 1'b1;
    tick();
    refund_ack = 1'b0;
  endtask

  task automatic wait_refund(input int max_cycles, output bit seen);
    seen = refund_valid;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      tick();
      seen = refund_valid;
    end
  endtask

  // Waits for a refund offer and compares it with the oldest scoreboard entry.
  task automatic drain_refund(input string name);
    bit seen;
    logic [7:0] exp;
    wait_refund(20, seen);
    checks++;
    if (!seen) begin
      failures++; $display("FAIL %s_refund_timeout got refund_valid=%b exp=1", name, refund_valid);
    end
    exp = (exp_refund_q.size() != 0) ? exp_refund_q.pop_front() : 8'hFF;
    checks++;
    if (refund_amount !== exp) begin
      failures++; $display("FAIL %s_refund_amount got=%0d exp=%0d", name, refund_amount, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    checks++;
    if ({credit, refund_amount, busy, coin_in, double_wash, timer_pause, refund_valid, coin_reject} !== 22'd0) begin
      failures++;
      $display("FAIL reset_outputs got credit=%0d busy=%b coin_in=%b dw=%b rv=%b exp all 0",
               credit, busy, coin_in, double_wash, refund_valid);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    coin(2'b10); coin(2'b00);
    checks++;
    if (credit !== 8'd5) begin failures++; $display("FAIL single_credit got=%0d exp=5", credit); end
    start(1'b0);
    checks++;
    if ({coin_in, busy, credit} !== {1'b1, 1'b1, 8'd1}) begin
      failures++; $display("FAIL single_start got coin_in=%b busy=%b credit=%0d exp 1 1 1", coin_in, busy, credit);
    end
    tick();
    checks++;
    if ({coin_in, busy} !== 2'b01) begin
      failures++; $display("FAIL single_pulse_len got coin_in=%b busy=%b exp 0 1", coin_in, busy);
    end
    exp_refund_q.push_back(8'd1);
    wash_done = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_end got=%b exp=0", busy); end
    drain_refund("single");
    ack();
    checks++;
    if ({refund_valid, credit} !== 9'd0) begin
      failures++; $display("FAIL single_ack got rv=%b credit=%0d exp 0 0", refund_valid, credit);
    end
    wash_done = 1'b0;
    tick();
  endtask

  task automatic test_double();
    coin(2'b10);
    start(1'b1);
    checks++;
    if ({coin_in, credit} !== {1'b0, 8'd4}) begin
      failures++; $display("FAIL double_short got coin_in=%b credit=%0d exp 0 4", coin_in, credit);
    end
    coin(2'b01);
    checks++;
    if (credit !== 8'd6) begin failures++; $display("FAIL double_credit got=%0d exp=6", credit); end
    start(1'b1);
    checks++;
    if ({coin_in, double_wash, credit} !== {1'b1, 1'b1, 8'd0}) begin
      failures++; $display("FAIL double_start got coin_in=%b dw=%b credit=%0d exp 1 1 0", coin_in, double_wash, credit);
    end
    tick(3);
    checks++;
    if (double_wash !== 1'b1) begin failures++; $display("FAIL double_hold got=%b exp=1", double_wash); end
    wash_done = 1'b1;
    tick();
    checks++;
    if ({double_wash, busy, refund_valid} !== 3'b000) begin
      failures++; $display("FAIL double_end got dw=%b busy=%b rv=%b exp 0 0 0", double_wash, busy, refund_valid);
    end
    wash_done = 1'b0;
    tick();
  endtask

  task automatic test_reject();
    coin(2'b11);
    checks++;
    if ({coin_reject, credit} !== {1'b1, 8'd0}) begin
      failures++; $display("FAIL reject_bad got rej=%b credit=%0d exp 1 0", coin_reject, credit);
    end
    tick();
    checks++;
    if (coin_reject !== 1'b0) begin failures++; $display("FAIL reject_pulse_len got=%b exp=0", coin_reject); end
    for (int i = 0; i < 4; i++) coin(2'b10);
    coin(2'b01);
    coin(2'b10);
    checks++;
    if ({coin_reject, credit} !== {1'b1, 8'd18}) begin
      failures++; $display("FAIL reject_overflow got rej=%b credit=%0d exp 1 18", coin_reject, credit);
    end
    coin(2'b01);
    checks++;
    if ({coin_reject, credit} !== {1'b0, 8'd20}) begin
      failures++; $display("FAIL reject_at_max got rej=%b credit=%0d exp 0 20", coin_reject, credit);
    end
    cancel_req = 1'b1; tick(); cancel_req = 1'b0;
    exp_refund_q.push_back(8'd20);
    drain_refund("max");
    ack();
  endtask

  task automatic test_cancel();
    coin(2'b01); coin(2'b00);
    cancel_req = 1'b1; tick(); cancel_req = 1'b0;
    exp_refund_q.push_back(8'd3);
    drain_refund("cancel");
    coin(2'b00);
    checks++;
    if ({coin_reject, refund_amount} !== {1'b1, 8'd3}) begin
      failures++; $display("FAIL cancel_coin_in_refund got rej=%b amt=%0d exp 1 3", coin_reject, refund_amount);
    end
    tick(3);
    checks++;
    if (refund_valid !== 1'b1) begin failures++; $display("FAIL cancel_hold got=%b exp=1", refund_valid); end
    ack();
    checks++;
    if ({refund_valid, credit} !== 9'd0) begin
      failures++; $display("FAIL cancel_ack got rv=%b credit=%0d exp 0 0", refund_valid, credit);
    end
  endtask

  task automatic test_timeout_pause();
    coin(2'b01);
    pause_req = 1'b1;
    tick(5);
    checks++;
    if ({refund_valid, timer_pause} !== 2'b00) begin
      failures++; $display("FAIL timeout_early got rv=%b tp=%b exp 0 0", refund_valid, timer_pause);
    end
    exp_refund_q.push_back(8'd2);
    drain_refund("timeout");
    ack();
    coin(2'b10);
    start(1'b0);
    tick();
    checks++;
    if (timer_pause !== 1'b1) begin failures++; $display("FAIL pause_in_wash got=%b exp=1", timer_pause); end
    pause_req = 1'b0;
    tick();
    checks++;
    if (timer_pause !== 1'b0) begin failures++; $display("FAIL pause_release got=%b exp=0", timer_pause); end
    wash_done = 1'b1; tick(); wash_done = 1'b0; tick();
  endtask

  task automatic test_done_high_and_reset();
    coin(2'b10);
    wash_done = 1'b1;
    start(1'b0);
    tick(4);
    checks++;
    if ({busy, refund_valid} !== 2'b10) begin
      failures++; $display("FAIL done_level_ignored got busy=%b rv=%b exp 1 0", busy, refund_valid);
    end
    wash_done = 1'b0; tick();
    wash_done = 1'b1; tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL done_new_edge got busy=%b exp=0", busy); end
    wash_done = 1'b0;
    coin(2'b10); coin(2'b10);
    start(1'b1);
    tick();
    checks++;
    if ({busy, double_wash, credit} !== {1'b1, 1'b1, 8'd2}) begin
      failures++; $display("FAIL midwash_pre got busy=%b dw=%b credit=%0d exp 1 1 2", busy, double_wash, credit);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, double_wash, credit} !== 10'd0) begin
      failures++; $display("FAIL midwash_reset got busy=%b dw=%b credit=%0d exp 0 0 0", busy, double_wash, credit);
    end
    tick(); rst = 1'b0; tick();
  endtask

  task automatic test_back_to_back();
    coin(2'b01);
    coin_valid = 1'b1; coin_code = 2'b00; cancel_req = 1'b1;
    tick();
    coin_valid = 1'b0; cancel_req = 1'b0;
    exp_refund_q.push_back(8'd2);
    checks++;
    if (coin_reject !== 1'b1) begin failures++; $display("FAIL prio_cancel_coin got rej=%b exp=1", coin_reject); end
    drain_refund("prio");
    ack();
    coin(2'b10);
    coin_valid = 1'b1; coin_code = 2'b00; start_req = 1'b1; double_sel = 1'b0;
    tick();
    coin_valid = 1'b0; start_req = 1'b0;
    checks++;
    if ({coin_reject, coin_in, credit} !== {1'b1, 1'b1, 8'd0}) begin
      failures++; $display("FAIL prio_start_coin got rej=%b coin_in=%b credit=%0d exp 1 1 0", coin_reject, coin_in, credit);
    end
    tick();
    wash_done = 1'b1; tick(); wash_done = 1'b0; tick();
    checks++;
    if (exp_refund_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_refund_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_double();
    test_reject();
    test_cancel();
    test_timeout_pause();
    test_done_high_and_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wash_payment_frontend.md
Name: wash_payment_frontend

Overview:
- Customer-facing payment and start front-end that drives washing_machine_controller as its initiator.
- Accepts coins, accumulates credit, and takes a single or double wash selection.
- Issues the one-cycle coin_in start pulse together with the double_wash level, then waits for the controller's wash_done.
- Returns unused credit through a refund handshake. Pause requests are gated onto timer_pause while a wash runs.

Parameters:
- CREDIT_W, 8, width of credit and refund counters (units)
- PRICE_SINGLE, 4, units charged for a single wash
- PRICE_DOUBLE, 6, units charged for a double wash
- CREDIT_MAX, 20, credit saturation limit in units
- IDLE_TIMEOUT, 1000000, cycles without activity in CREDIT before auto-refund

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- coin_valid  in  1  one-cycle strobe: coin detected
- coin_code  in  2  coin value: 00=1 unit, 01=2, 10=4, 11=invalid
- coin_reject  out  1  one-cycle pulse: coin not accepted
- start_req  in  1  one-cycle strobe: customer start button
- double_sel  in  1  level sampled with start_req: 1 = double wash
- cancel_req  in  1  one-cycle strobe: customer cancel
- pause_req  in  1  level: customer pause request
- credit  out  CREDIT_W  current credit in units
- busy  out  1  high from start pulse until wash_done seen
- coin_in  out  1  to controller: one-cycle start pulse
- double_wash  out  1  to controller: wash mode, held through the wash
- timer_pause  out  1  to controller: pause_req gated by busy
- wash_done  in  1  from controller: level, high when wash finished
- refund_valid  out  1  refund request to the coin hopper
- refund_amount  out  CREDIT_W  units to return, stable while refund_valid
- refund_ack  in  1  one-cycle hopper acknowledge

Behaviour:
- Reset: clk and rst as above; rst is asynchronous and active-high. All outputs are 0 in reset. credit=0, state=IDLE, wash_done edge register=0.
- States:
  - IDLE: credit=0.
  - CREDIT: credit>0.
  - START: one cycle; coin_in=1.
  - WASH: wait for wash_done.
  - REFUND: refund_valid=1 until refund_ack.
- Coin handling, legal only in IDLE and CREDIT:
  - Valid code with credit+value<=CREDIT_MAX: credit += value on the next edge; IDLE->CREDIT.
  - Code 11, value overflowing CREDIT_MAX, or a coin in START/WASH/REFUND: coin_reject pulses 1 cycle later and credit is unchanged.
- Start: start_req in CREDIT with credit>=price (PRICE_DOUBLE if double_sel else PRICE_SINGLE):
  - Deduct the price, latch double_sel into double_wash, go to START.
  - Next cycle coin_in=1 for exactly 1 cycle, busy=1, then WASH.
  - start_req with insufficient credit is ignored. start_req in IDLE is ignored.
- Pause: timer_pause = pause_req & busy, registered (1-cycle latency).
- WASH exit: a rising edge of wash_done, detected against the previous sample, ends the wash.
  - wash_done already high on WASH entry does not count; an edge is required.
  - On the edge: busy=0, double_wash=0. Remaining credit>0 -> REFUND, else -> IDLE.
- Cancel: cancel_req in CREDIT -> REFUND of the full credit. cancel_req in START/WASH is ignored; a wash is never aborted.
- Idle timeout: counter clears on any coin_valid, start_req or cancel_req. Reaching IDLE_TIMEOUT in CREDIT -> REFUND.
- REFUND:
  - refund_amount=credit, refund_valid held high.
  - On refund_ack: credit=0, refund_valid=0 the same edge, go to IDLE.
  - refund_ack outside REFUND is ignored.
- Simultaneous events in CREDIT, priority: cancel_req > start_req > coin_valid > timeout. The losing coin is rejected with a coin_reject pulse.
- Reset mid-wash: everything returns to reset values. Credit is lost by design; the controller is expected to share the reset.

Decomposition:
- Shared package wash_pkg: state enum, coin code localparams, coin value lookup function, default prices. The controller reuses the same package.
- One natural sub-module: wash_coin_decoder, which handles code-to-value mapping, the overflow check and the coin_reject pulse.

Test Plan:
- Coins 10 then 00 (credit 5), start_req with double_sel=0 -> credit=1 and coin_in high exactly 1 cycle after start; on the wash_done rise, refund_valid with refund_amount=1; ack -> IDLE, credit 0.
- Credit 4, start_req with double_sel=1 -> ignored, credit stays 4, no coin_in; add coin 01 -> credit 6; start -> double_wash=1 held until the wash_done edge, credit 0, then IDLE with no refund.
- coin_code=11 -> coin_reject 1 cycle, credit unchanged; credit 18 + coin 10 -> rejected, credit stays 18.
- Credit 3, cancel_req -> refund_amount=3; refund_ack 5 cycles later -> IDLE; coin during REFUND -> rejected.
- Credit 2, no activity for IDLE_TIMEOUT cycles (set to 10 in the test) -> REFUND of 2; pause_req=1 in CREDIT -> timer_pause stays 0; in WASH -> timer_pause=1 one cycle later.
- wash_done already high when WASH is entered -> stays in WASH until wash_done falls and rises again; assert rst mid-WASH -> busy, double_wash and credit are immediately 0.
